decode_stage_ctrl: RTL and testbench
====================================

Name: decode_stage_ctrl

Overview:
- Decode-stage controller for the RV32I pipeline, between fetch and execute.
- Accepts one instruction word per handshake and classifies its opcode.
- Drives the immediate-generator sub-module with the 25-bit instruction field and the selected imm_type.
- Registers the decoded bundle into a 2-entry skid buffer with valid/ready on both sides, plus flush and illegal-instruction accounting.

Parameters:
- XLEN, 32, instruction, PC and immediate width; fixed at 32.
- CNT_W, 8, width of the saturating illegal-instruction counter.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- flush  in  1  synchronous pipeline flush (branch mispredict or trap).
- in_valid  in  1  fetch has an instruction.
- in_ready  out  1  decode can accept.
- in_instr  in  32  instruction word.
- in_pc  in  32  PC of the instruction.
- out_valid  out  1  decoded bundle valid.
- out_ready  in  1  execute accepts.
- out_pc  out  32  registered PC.
- out_instr  out  32  registered instruction.
- out_imm  out  32  generated immediate.
- out_imm_type  out  3  0=I, 1=B, 2=S, 3=U, 4=J, 5=SH (SH only with the feature).
- out_has_imm  out  1  instruction carries an immediate.
- out_rd, out_rs1, out_rs2  out  5 each  register fields.
- out_funct3  out  3  funct3 field.
- out_illegal  out  1  unrecognised opcode or instr[1:0] != 2'b11.
- illegal_cnt  out  CNT_W  saturating count of illegal instructions accepted.

Behaviour:
- Reset (rst_n low, asynchronous):
  - All out_* payload = 0, out_valid = 0, illegal_cnt = 0.
  - in_ready = 1 after release.
  - FSM = EMPTY.
- Opcode classification (combinational on in_instr[6:0]):
  - 0000011, 0010011, 1100111, 1110011, 0001111 -> I.
  - 0100011 -> S.
  - 1100011 -> B.
  - 0110111, 0010111 -> U.
  - 1101111 -> J.
  - 0110011 -> R: has_imm = 0, imm_type = 0, imm forced to 0.
  - Anything else -> illegal: has_imm = 0, imm = 0, imm_type = 0.
- Immediate generation:
  - The immediate generator receives in_instr[31:7] and the class-selected type.
  - Its output is captured with the bundle. Latency from accept to out_valid is 1 cycle.
- Handshakes:
  - Accept = in_valid & in_ready.
  - Output transfer = out_valid & out_ready.
  - Payload is stable while out_valid & !out_ready.
  - in_ready is a registered signal: in_ready = (state != FULL).
- FSM states: EMPTY, ONE (output register valid), FULL (output register and skid register valid).
  - EMPTY: accept -> ONE.
  - ONE:
    - accept & !xfer -> FULL (new bundle goes to skid).
    - accept & xfer -> ONE (output register reloads directly).
    - !accept & xfer -> EMPTY.
  - FULL: no accept possible. xfer -> ONE (skid moves to output register).
- Flush:
  - Next state is EMPTY, out_valid = 0 next cycle, skid cleared.
  - Any accept in the flush cycle is discarded, and its illegal flag does not count.
  - Flush has priority over all other transitions.
- illegal_cnt:
  - Increments by 1 per accepted illegal instruction, counted at accept, not at output.
  - Saturates at 2^CNT_W-1 with no wrap.
- Reset mid-transfer drops all buffered entries immediately.

Optional Feature:
- Macro: DECODE_SHAMT_EN.
- Defined:
  - OP-IMM with funct3 001 or 101 (SLLI/SRLI/SRAI) -> out_imm_type = 5.
  - out_imm = {27'b0, instr[24:20]}, generated locally because the immediate generator returns all-ones for type 5.
  - instr[30] is excluded from the immediate.
  - OP-IMM funct3 001 with instr[31:25] != 0, or 101 with instr[31:25] not 0000000/0100000 -> out_illegal = 1.
- Undefined: shifts decode as plain I-type, out_imm = sign-extended instr[31:20], with no shamt legality check.

Decomposition:
- Shared package decode_pkg holds:
  - Opcode constants OPC_LOAD … OPC_SYSTEM.
  - imm_type constants IMM_I=0, IMM_B=1, IMM_S=2, IMM_U=3, IMM_J=4, IMM_SH=5.
  - FSM state encoding (EMPTY, ONE, FULL).
  - The decoded-bundle struct typedef.
- One natural sub-module: the existing immediate generator imm32, instantiated unchanged. Opcode classification stays inline.

Test Plan:
- ADDI 0xFFF00093 accepted, out_ready = 1 -> next cycle:
  - out_valid = 1, out_imm = 0xFFFFFFFF, type 0, rd = 1.
- Back-to-back feed with no stalls:
  - LUI 0x123452B7 -> imm 0x12345000, type 3.
  - JAL 0xFFDFF06F -> imm 0xFFFFFFFC, type 4.
  - BEQ 0x00000463 -> imm 0x00000008, type 1.
  - SW 0x0020A223 -> imm 0x00000004, type 2.
  - Expect one bundle per cycle and in_ready held at 1.
- out_ready = 0 while feeding 3 instructions:
  - After 2 accepts, state = FULL and in_ready = 0.
  - Release out_ready: bundles emerge in order with no loss or duplication.
- flush asserted in FULL, with in_valid = 1 on an illegal word 0x0000007F:
  - Next cycle out_valid = 0, state EMPTY, illegal_cnt unchanged.
- 300 illegal words (0x00000000) accepted with CNT_W = 8 -> illegal_cnt = 255 and holds.
- SRAI 0x4030D093:
  - DECODE_SHAMT_EN defined -> type 5, imm 0x00000003, out_illegal = 0.
  - Undefined -> type 0, imm 0x00000403.

Source files
------------

// File: rtl/decode_pkg.sv
// Shared definitions for the RV32I decode stage: opcodes, immediate type
// codes, the skid-buffer state encoding and the decoded bundle.
package decode_pkg;

  localparam int XLEN_C = 32;

  // RV32I major opcodes (instr[6:0])
  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

  // Immediate format codes shared with imm32
  localparam logic [2:0] IMM_I  = 3'd0;
  localparam logic [2:0] IMM_B  = 3'd1;
  localparam logic [2:0] IMM_S  = 3'd2;
  localparam logic [2:0] IMM_U  = 3'd3;
  localparam logic [2:0] IMM_J  = 3'd4;
  localparam logic [2:0] IMM_SH = 3'd5;

  // Occupancy of the two-entry output/skid buffer
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_e;

  // One decoded instruction as it travels to execute
  typedef struct packed {
    logic [XLEN_C-1:0] pc;
    logic [XLEN_C-1:0] instr;
    logic [XLEN_C-1:0] imm;
    logic [2:0]        imm_type;
    logic              has_imm;
    logic [4:0]        rd;
    logic [4:0]        rs1;
    logic [4:0]        rs2;
    logic [2:0]        funct3;
    logic              illegal;
  } bundle_t;

endpackage

// File: rtl/imm32.sv
// RV32I immediate generator. Takes instr[31:7] and a format code and returns
// the sign-extended 32-bit immediate. Unknown codes (including the shift
// format) return all ones; the caller builds shift amounts itself.
module imm32
  import decode_pkg::*;
(
  input  logic [24:0] instr_hi_i,
  input  logic [2:0]  imm_type_i,
  output logic [31:0] imm_o
);

  // Bit k of instr_hi_i is instr[k+7]
  logic sgn;
  assign sgn = instr_hi_i[24];

  // Format multiplexer
  always_comb begin
    imm_o = '1;
    case (imm_type_i)
      IMM_I: imm_o = {{20{sgn}}, instr_hi_i[24:13]};
      IMM_S: imm_o = {{20{sgn}}, instr_hi_i[24:18], instr_hi_i[4:0]};
      IMM_B: imm_o = {{20{sgn}}, instr_hi_i[0], instr_hi_i[23:18],
                      instr_hi_i[4:1], 1'b0};
      IMM_U: imm_o = {instr_hi_i[24:5], 12'b0};
      IMM_J: imm_o = {{12{sgn}}, instr_hi_i[12:5], instr_hi_i[13],
                      instr_hi_i[23:14], 1'b0};
      default: imm_o = '1;
    endcase
  end

endmodule

// File: rtl/decode_stage_ctrl.sv
// RV32I decode stage: classifies the opcode, generates the immediate through
// imm32 and registers the bundle into a two-entry skid buffer.
// Optional macro DECODE_SHAMT_EN: decode SLLI/SRLI/SRAI as shift-amount
// immediates (type 5) with funct7 legality checking.
//
// Handshake: a beat moves on a side when valid & ready are both high at the
// rising edge; valid never depends on ready, and the output payload holds
// while out_valid & !out_ready. in_ready is registered (high unless FULL).
module decode_stage_ctrl
  import decode_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [XLEN-1:0]  in_instr,
  input  logic [XLEN-1:0]  in_pc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_pc,
  output logic [XLEN-1:0]  out_instr,
  output logic [XLEN-1:0]  out_imm,
  output logic [2:0]       out_imm_type,
  output logic             out_has_imm,
  output logic [4:0]       out_rd,
  output logic [4:0]       out_rs1,
  output logic [4:0]       out_rs2,
  output logic [2:0]       out_funct3,
  output logic             out_illegal,
  output logic [CNT_W-1:0] illegal_cnt,
  output logic [1:0]       dbg_state_o
);

  state_e            state_q, state_d;
  bundle_t           out_q, out_d;
  bundle_t           skid_q, skid_d;
  logic              in_ready_q;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic [6:0]  opc;
  logic [2:0]  f3;
  logic [2:0]  imm_type;
  logic        has_imm;
  logic        illegal;
  logic [31:0] gen_imm;
  bundle_t     dec;
  logic        accept;
  logic        xfer;

  assign opc    = in_instr[6:0];
  assign f3     = in_instr[14:12];
  assign accept = in_valid & in_ready_q;
  assign xfer   = (state_q != ST_EMPTY) & out_ready;

  // Opcode classification and immediate format selection
  always_comb begin
    imm_type = IMM_I;
    has_imm  = 1'b0;
    illegal  = 1'b0;
    case (opc)
      OPC_LOAD, OPC_OP_IMM, OPC_JALR, OPC_SYSTEM, OPC_MISC_MEM: begin
        has_imm  = 1'b1;
        imm_type = IMM_I;
      end
      OPC_STORE:           begin has_imm = 1'b1; imm_type = IMM_S; end
      OPC_BRANCH:          begin has_imm = 1'b1; imm_type = IMM_B; end
      OPC_LUI, OPC_AUIPC:  begin has_imm = 1'b1; imm_type = IMM_U; end
      OPC_JAL:             begin has_imm = 1'b1; imm_type = IMM_J; end
      OPC_OP:              begin has_imm = 1'b0; imm_type = IMM_I; end
      default:             illegal = 1'b1;
    endcase
`ifdef DECODE_SHAMT_EN
    if (opc == OPC_OP_IMM && (f3 == 3'b001 || f3 == 3'b101)) begin
      imm_type = IMM_SH;
      if (f3 == 3'b001 && in_instr[31:25] != 7'b0000000)
        illegal = 1'b1;
      if (f3 == 3'b101 && in_instr[31:25] != 7'b0000000 &&
          in_instr[31:25] != 7'b0100000)
        illegal = 1'b1;
    end
`endif
    if (in_instr[1:0] != 2'b11)
      illegal = 1'b1;
    // Illegal words carry no immediate at all
    if (illegal) begin
      has_imm  = 1'b0;
      imm_type = IMM_I;
    end
  end

  imm32 u_imm32 (
    .instr_hi_i (in_instr[31:7]),
    .imm_type_i (imm_type),
    .imm_o      (gen_imm)
  );

  // Assemble the decoded bundle for the incoming word
  always_comb begin
    dec          = '0;
    dec.pc       = in_pc;
    dec.instr    = in_instr;
    dec.imm_type = imm_type;
    dec.has_imm  = has_imm;
    dec.rd       = in_instr[11:7];
    dec.rs1      = in_instr[19:15];
    dec.rs2      = in_instr[24:20];
    dec.funct3   = f3;
    dec.illegal  = illegal;
    dec.imm      = has_imm ? gen_imm : '0;
`ifdef DECODE_SHAMT_EN
    // imm32 yields all ones for shifts; instr[30] is not part of shamt
    if (has_imm && imm_type == IMM_SH)
      dec.imm = {27'b0, in_instr[24:20]};
`endif
  end

  // Buffer occupancy, data movement and illegal accounting
  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    skid_d  = skid_q;
    cnt_d   = cnt_q;
    if (flush) begin
      state_d = ST_EMPTY;
      skid_d  = '0;
    end else begin
      if (accept && illegal && cnt_q != {CNT_W{1'b1}})
        cnt_d = cnt_q + 1'b1;
      case (state_q)
        ST_EMPTY: begin
          if (accept) begin
            state_d = ST_ONE;
            out_d   = dec;
          end
        end
        ST_ONE: begin
          if (accept && !xfer) begin
            state_d = ST_FULL;
            skid_d  = dec;
          end else if (accept && xfer) begin
            out_d = dec;
          end else if (xfer) begin
            state_d = ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (xfer) begin
            state_d = ST_ONE;
            out_d   = skid_q;
            skid_d  = '0;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end
  end

  // State, payload and counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_EMPTY;
      out_q      <= '0;
      skid_q     <= '0;
      cnt_q      <= '0;
      in_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      out_q      <= out_d;
      skid_q     <= skid_d;
      cnt_q      <= cnt_d;
      in_ready_q <= (state_d != ST_FULL);
    end
  end

  assign in_ready     = in_ready_q;
  assign out_valid    = (state_q != ST_EMPTY);
  assign out_pc       = out_q.pc;
  assign out_instr    = out_q.instr;
  assign out_imm      = out_q.imm;
  assign out_imm_type = out_q.imm_type;
  assign out_has_imm  = out_q.has_imm;
  assign out_rd       = out_q.rd;
  assign out_rs1      = out_q.rs1;
  assign out_rs2      = out_q.rs2;
  assign out_funct3   = out_q.funct3;
  assign out_illegal  = out_q.illegal;
  assign illegal_cnt  = cnt_q;
  assign dbg_state_o  = state_q;

endmodule

// File: tb/tb_decode_stage_ctrl.sv
// Directed bench for decode_stage_ctrl. Inputs change and outputs are
// sampled on the falling clock edge.
module tb_decode_stage_ctrl;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic [31:0] in_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_instr;
  logic [31:0] out_imm;
  logic [2:0]  out_imm_type;
  logic        out_has_imm;
  logic [4:0]  out_rd;
  logic [4:0]  out_rs1;
  logic [4:0]  out_rs2;
  logic [2:0]  out_funct3;
  logic        out_illegal;
  logic [7:0]  illegal_cnt;
  logic [1:0]  dbg_state;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];

  decode_stage_ctrl #(.XLEN(32), .CNT_W(8)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .flush        (flush),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_instr     (in_instr),
    .in_pc        (in_pc),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_pc       (out_pc),
    .out_instr    (out_instr),
    .out_imm      (out_imm),
    .out_imm_type (out_imm_type),
    .out_has_imm  (out_has_imm),
    .out_rd       (out_rd),
    .out_rs1      (out_rs1),
    .out_rs2      (out_rs2),
    .out_funct3   (out_funct3),
    .out_illegal  (out_illegal),
    .illegal_cnt  (illegal_cnt),
    .dbg_state_o  (dbg_state)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // One accepted instruction from EMPTY with out_ready high; returns at the
  // falling edge where the bundle is on the outputs.
  task automatic send_one(input logic [31:0] instr, input logic [31:0] pc);
    in_valid = 1'b1;
    in_instr = instr;
    in_pc    = pc;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  logic [31:0] bb_instr [4] = '{32'h123452B7, 32'hFFDFF06F, 32'h00000463, 32'h0020A223};
  logic [31:0] bb_imm   [4] = '{32'h12345000, 32'hFFFFFFFC, 32'h00000008, 32'h00000004};
  logic [2:0]  bb_type  [4] = '{3'd3, 3'd4, 3'd1, 3'd2};

  initial begin
    logic acc_prev;
    int   popped;
    // Reset
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_instr = '0; in_pc = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_out_valid", {31'b0, out_valid}, 32'd0);
    check("rst_in_ready", {31'b0, in_ready}, 32'd1);
    check("rst_cnt", {24'b0, illegal_cnt}, 32'd0);
    check("rst_out_pc", out_pc, 32'd0);
    check("rst_state", {30'b0, dbg_state}, 32'd0);

    // ADDI x1, x0, -1
    send_one(32'hFFF00093, 32'h100);
    check("addi_valid", {31'b0, out_valid}, 32'd1);
    check("addi_imm", out_imm, 32'hFFFFFFFF);
    check("addi_type", {29'b0, out_imm_type}, 32'd0);
    check("addi_rd", {27'b0, out_rd}, 32'd1);
    check("addi_pc", out_pc, 32'h100);
    check("addi_has_imm", {31'b0, out_has_imm}, 32'd1);
    @(negedge clk);
    check("addi_drain_state", {30'b0, dbg_state}, 32'd0);

    // ADD x3, x1, x2 : register form, no immediate
    send_one(32'h002081B3, 32'h104);
    check("add_has_imm", {31'b0, out_has_imm}, 32'd0);
    check("add_imm", out_imm, 32'd0);
    check("add_regs", {17'b0, out_rd, out_rs1, out_rs2}, {17'b0, 5'd3, 5'd1, 5'd2});
    check("add_illegal", {31'b0, out_illegal}, 32'd0);
    @(negedge clk);

    // Back-to-back stream, one bundle per cycle
    for (int i = 0; i <= 4; i++) begin
      if (i > 0) begin
        check("bb_valid", {31'b0, out_valid}, 32'd1);
        check("bb_imm", out_imm, bb_imm[i-1]);
        check("bb_type", {29'b0, out_imm_type}, {29'b0, bb_type[i-1]});
        check("bb_in_ready", {31'b0, in_ready}, 32'd1);
      end
      if (i < 4) begin
        in_valid = 1'b1;
        in_instr = bb_instr[i];
        in_pc    = 32'h1000 + 32'(i * 4);
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
    end
    check("bb_drain_valid", {31'b0, out_valid}, 32'd0);

    // Stall: three offered, two accepted, buffer FULL
    out_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1;
      in_instr = 32'h00000013;
      in_pc    = 32'h200 + 32'(i * 4);
      exp_q.push_back(in_pc);
      @(negedge clk);
    end
    in_pc = 32'h208;
    exp_q.push_back(32'h208);
    check("stall_state_full", {30'b0, dbg_state}, 32'd2);
    check("stall_in_ready", {31'b0, in_ready}, 32'd0);
    @(negedge clk);
    check("stall_hold_pc", out_pc, 32'h200);
    out_ready = 1'b1;
    acc_prev  = 1'b0;
    popped    = 0;
    for (int cyc = 0; cyc < 10; cyc++) begin
      if (acc_prev) in_valid = 1'b0;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) check("stall_extra_out", out_pc, 32'hDEADBEEF);
        else check("stall_order", out_pc, exp_q.pop_front());
        popped++;
      end
      acc_prev = in_valid && in_ready;
      @(negedge clk);
    end
    check("stall_popped", popped, 32'd3);
    check("stall_q_empty", exp_q.size(), 32'd0);

    // Flush while FULL with an illegal word offered
    out_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1; in_instr = 32'h00000013; in_pc = 32'h300 + 32'(i * 4);
      @(negedge clk);
    end
    check("fl_full", {30'b0, dbg_state}, 32'd2);
    flush = 1'b1; in_instr = 32'h0000007F;
    @(negedge clk);
    flush = 1'b0; in_valid = 1'b0;
    check("fl_valid", {31'b0, out_valid}, 32'd0);
    check("fl_state", {30'b0, dbg_state}, 32'd0);
    check("fl_cnt", {24'b0, illegal_cnt}, 32'd0);
    check("fl_in_ready", {31'b0, in_ready}, 32'd1);

    // Flush in ONE while an illegal word is actually acceptable
    in_valid = 1'b1; in_instr = 32'h00000013; in_pc = 32'h400;
    @(negedge clk);
    flush = 1'b1; in_instr = 32'h0000007F;
    @(negedge clk);
    flush = 1'b0; in_valid = 1'b0;
    check("fl1_state", {30'b0, dbg_state}, 32'd0);
    check("fl1_cnt", {24'b0, illegal_cnt}, 32'd0);
    out_ready = 1'b1;
    @(negedge clk);

    // Illegal counter saturation
    in_valid = 1'b1; in_instr = 32'h00000000;
    repeat (10) @(negedge clk);
    check("cnt_10", {24'b0, illegal_cnt}, 32'd10);
    check("cnt_out_illegal", {31'b0, out_illegal}, 32'd1);
    check("cnt_illegal_imm", out_imm, 32'd0);
    repeat (290) @(negedge clk);
    check("cnt_sat", {24'b0, illegal_cnt}, 32'd255);
    repeat (5) @(negedge clk);
    check("cnt_hold", {24'b0, illegal_cnt}, 32'd255);
    in_valid = 1'b0;
    @(negedge clk);

    // SRAI x1, x1, 3
    send_one(32'h4030D093, 32'h500);
`ifdef DECODE_SHAMT_EN
    check("srai_type", {29'b0, out_imm_type}, 32'd5);
    check("srai_imm", out_imm, 32'h00000003);
    check("srai_illegal", {31'b0, out_illegal}, 32'd0);
    @(negedge clk);
    send_one(32'h02009093, 32'h504);
    check("slli_bad_illegal", {31'b0, out_illegal}, 32'd1);
`else
    check("srai_type", {29'b0, out_imm_type}, 32'd0);
    check("srai_imm", out_imm, 32'h00000403);
    check("srai_illegal", {31'b0, out_illegal}, 32'd0);
`endif
    @(negedge clk);

    // Asynchronous reset with a bundle buffered
    out_ready = 1'b0;
    send_one(32'h00000013, 32'h600);
    check("pre_rst_valid", {31'b0, out_valid}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_valid", {31'b0, out_valid}, 32'd0);
    check("async_rst_pc", out_pc, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_state", {30'b0, dbg_state}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
